// File: rtl/fifo_pkg.sv
// Constants shared by the async FIFO write source and the write/read pointer blocks.
package fifo_pkg;

  localparam int unsigned D_SIZE = 8;
  localparam int unsigned P_SIZE = 4;

  // Skid buffer occupancy states
  localparam logic [1:0] ST_EMPTY = 2'd0;
  localparam logic [1:0] ST_ONE   = 2'd1;
  localparam logic [1:0] ST_TWO   = 2'd2;

endpackage

// File: rtl/fifo_wr_src_if.sv
// Upstream stream plus FIFO write-port signals of the write-domain source.
interface fifo_wr_src_if #(
  parameter int unsigned D_SIZE = fifo_pkg::D_SIZE
) ();

  logic              s_valid;
  logic [D_SIZE-1:0] s_data;
  logic              s_ready;
  logic              full;
  logic              w_inc;
  logic [D_SIZE-1:0] w_data;

  modport master (
    input  s_valid, s_data, full,
    output s_ready, w_inc, w_data
  );

  modport slave (
    output s_valid, s_data, full,
    input  s_ready, w_inc, w_data
  );

endinterface

// File: rtl/fifo_skid_buf.sv
// Two-entry skid buffer: head is the word presented for popping, tail the second word.
module fifo_skid_buf #(
  parameter int unsigned D_SIZE = fifo_pkg::D_SIZE
) (
  input  logic              w_clk,
  input  logic              w_rstn,
  input  logic              rdy,
  input  logic              s_valid,
  input  logic [D_SIZE-1:0] s_data,
  output logic              s_ready,
  input  logic              pop_req,
  input  logic              flush,
  output logic              pop,
  output logic              pop_valid,
  output logic [D_SIZE-1:0] pop_data
);
  import fifo_pkg::*;

  logic [1:0]        cnt_q, cnt_d;
  logic [D_SIZE-1:0] head_q, head_d;
  logic [D_SIZE-1:0] tail_q, tail_d;
  logic              acc;

  assign pop_valid = (cnt_q != ST_EMPTY);
  assign s_ready   = rdy & (cnt_q != ST_TWO) & ~flush;
  assign acc       = s_valid & s_ready;
  assign pop       = pop_valid & pop_req & ~flush;
  assign pop_data  = head_q;

  always_comb begin
    cnt_d  = cnt_q;
    head_d = head_q;
    tail_d = tail_q;
    if (flush) begin
      cnt_d  = ST_EMPTY;
      head_d = '0;
      tail_d = '0;
    end else begin
      case (cnt_q)
        ST_EMPTY: begin
          if (acc) begin
            head_d = s_data;
            cnt_d  = ST_ONE;
          end
        end
        ST_ONE: begin
          if (acc && !pop) begin
            tail_d = s_data;
            cnt_d  = ST_TWO;
          end else if (acc && pop) begin
            head_d = s_data;
          end else if (pop) begin
            // Cleared so w_data reads 0 while empty
            head_d = '0;
            cnt_d  = ST_EMPTY;
          end
        end
        ST_TWO: begin
          if (pop) begin
            head_d = tail_q;
            tail_d = '0;
            cnt_d  = ST_ONE;
          end
        end
        default: begin
          cnt_d  = ST_EMPTY;
          head_d = '0;
          tail_d = '0;
        end
      endcase
    end
  end

  always_ff @(posedge w_clk or negedge w_rstn) begin
    if (!w_rstn) begin
      cnt_q  <= ST_EMPTY;
      head_q <= '0;
      tail_q <= '0;
    end else begin
      cnt_q  <= cnt_d;
      head_q <= head_d;
      tail_q <= tail_d;
    end
  end

endmodule

// File: rtl/fifo_wr_src.sv
// Write-domain FIFO producer: skid-buffered upstream stream, full/en gated write strobe,
// and write-side statistics.
module fifo_wr_src #(
  parameter int unsigned D_SIZE = fifo_pkg::D_SIZE,
  parameter int unsigned C_SIZE = 16
) (
  input  logic              w_clk,
  input  logic              w_rstn,
  fifo_wr_src_if.master     bus,
  input  logic              en,
  input  logic              flush,
  input  logic              clr_stats,
  output logic [C_SIZE-1:0] wr_words,
  output logic [C_SIZE-1:0] stall_cnt
);
  import fifo_pkg::*;

  logic              rdy_q;
  logic              pop;
  logic              pop_valid;
  logic [D_SIZE-1:0] pop_data;
  logic              stall;
  logic [C_SIZE-1:0] wr_words_q, wr_words_d;
  logic [C_SIZE-1:0] stall_cnt_q, stall_cnt_d;

  fifo_skid_buf #(
    .D_SIZE (D_SIZE)
  ) u_skid (
    .w_clk     (w_clk),
    .w_rstn    (w_rstn),
    .rdy       (rdy_q),
    .s_valid   (bus.s_valid),
    .s_data    (bus.s_data),
    .s_ready   (bus.s_ready),
    .pop_req   (en & ~bus.full),
    .flush     (flush),
    .pop       (pop),
    .pop_valid (pop_valid),
    .pop_data  (pop_data)
  );

  assign bus.w_inc  = pop;
  assign bus.w_data = pop_data;
  assign stall      = pop_valid & en & bus.full & ~flush;

  always_comb begin
    wr_words_d  = wr_words_q + {{(C_SIZE-1){1'b0}}, pop};
    stall_cnt_d = stall_cnt_q;
    if (stall && (stall_cnt_q != {C_SIZE{1'b1}})) begin
      stall_cnt_d = stall_cnt_q + {{(C_SIZE-1){1'b0}}, 1'b1};
    end
    if (clr_stats) begin
      wr_words_d  = '0;
      stall_cnt_d = '0;
    end
  end

  // rdy_q keeps s_ready low until the first clock edge after reset release
  always_ff @(posedge w_clk or negedge w_rstn) begin
    if (!w_rstn) begin
      rdy_q       <= 1'b0;
      wr_words_q  <= '0;
      stall_cnt_q <= '0;
    end else begin
      rdy_q       <= 1'b1;
      wr_words_q  <= wr_words_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign wr_words  = wr_words_q;
  assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_fifo_wr_src.sv
// Directed bench for fifo_wr_src; counters use C_SIZE=5 so wrap and saturation are reachable.
module tb_fifo_wr_src;

  localparam int unsigned DW = 8;
  localparam int unsigned CW = 5;

  logic          w_clk = 1'b0;
  logic          w_rstn;
  logic          en;
  logic          flush;
  logic          clr_stats;
  logic [CW-1:0] wr_words;
  logic [CW-1:0] stall_cnt;
  int            total = 0;
  int            bad   = 0;

  fifo_wr_src_if #(.D_SIZE(DW)) wif ();

  fifo_wr_src #(
    .D_SIZE (DW),
    .C_SIZE (CW)
  ) dut (
    .w_clk     (w_clk),
    .w_rstn    (w_rstn),
    .bus       (wif.master),
    .en        (en),
    .flush     (flush),
    .clr_stats (clr_stats),
    .wr_words  (wr_words),
    .stall_cnt (stall_cnt)
  );

  always #5 w_clk = ~w_clk;

  task automatic cyc();
    @(posedge w_clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    w_rstn = 1'b0; en = 1'b1; flush = 1'b0; clr_stats = 1'b0;
    wif.s_valid = 1'b0; wif.s_data = '0; wif.full = 1'b0;
    repeat (2) cyc();
    #2;
    chk("rst_s_ready", 32'(wif.s_ready), 0);
    chk("rst_w_inc", 32'(wif.w_inc), 0);
    chk("rst_w_data", 32'(wif.w_data), 0);
    chk("rst_words", 32'(wr_words), 0);
    chk("rst_stall", 32'(stall_cnt), 0);

    // Reset release: first cycle not ready, then accept 0x11
    cyc();
    w_rstn = 1'b1; wif.s_valid = 1'b1; wif.s_data = 8'h11;
    #2 chk("rel_not_ready", 32'(wif.s_ready), 0);
    cyc();
    #2 chk("rel_ready", 32'(wif.s_ready), 1);
    chk("rel_no_inc", 32'(wif.w_inc), 0);
    cyc();
    wif.s_valid = 1'b0;
    #2 chk("first_inc", 32'(wif.w_inc), 1);
    chk("first_data", 32'(wif.w_data), 32'h11);
    cyc();
    #2 chk("first_words", 32'(wr_words), 1);
    chk("first_idle", 32'(wif.w_inc), 0);
    chk("empty_data0", 32'(wif.w_data), 0);

    // Back-to-back stream 0x01..0x08
    for (int i = 1; i <= 8; i++) begin
      cyc();
      wif.s_valid = 1'b1; wif.s_data = 8'(i);
      #2 chk("strm_ready", 32'(wif.s_ready), 1);
      if (i > 1) begin
        chk("strm_inc", 32'(wif.w_inc), 1);
        chk("strm_data", 32'(wif.w_data), 32'(i - 1));
      end
    end
    cyc();
    wif.s_valid = 1'b0;
    #2 chk("strm_last_inc", 32'(wif.w_inc), 1);
    chk("strm_last_data", 32'(wif.w_data), 8);
    cyc();
    #2 chk("strm_idle", 32'(wif.w_inc), 0);
    chk("strm_words", 32'(wr_words), 9);

    // Full back-pressure with A0/A1/A2
    cyc();
    wif.full = 1'b1; wif.s_valid = 1'b1; wif.s_data = 8'hA0;
    #2 chk("full_acc0", 32'(wif.s_ready), 1);
    chk("full_noinc0", 32'(wif.w_inc), 0);
    cyc();
    wif.s_data = 8'hA1;
    #2 chk("full_acc1", 32'(wif.s_ready), 1);
    chk("full_noinc1", 32'(wif.w_inc), 0);
    cyc();
    wif.s_data = 8'hA2;
    #2 chk("full_blocked", 32'(wif.s_ready), 0);
    chk("full_noinc2", 32'(wif.w_inc), 0);
    chk("full_stall1", 32'(stall_cnt), 1);
    cyc();
    #2 chk("full_stall2", 32'(stall_cnt), 2);
    wif.full = 1'b0;
    #1 chk("rel_blocked", 32'(wif.s_ready), 0);
    chk("rel_inc_a0", 32'(wif.w_inc), 1);
    chk("rel_data_a0", 32'(wif.w_data), 32'hA0);
    cyc();
    #2 chk("rel_acc_a2", 32'(wif.s_ready), 1);
    chk("rel_data_a1", 32'(wif.w_data), 32'hA1);
    cyc();
    wif.s_valid = 1'b0;
    #2 chk("rel_inc_a2", 32'(wif.w_inc), 1);
    chk("rel_data_a2", 32'(wif.w_data), 32'hA2);
    cyc();
    #2 chk("rel_idle", 32'(wif.w_inc), 0);
    chk("rel_words", 32'(wr_words), 12);
    chk("rel_stall_hold", 32'(stall_cnt), 2);

    // Simultaneous push/pop in ONE
    cyc();
    wif.s_valid = 1'b1; wif.s_data = 8'h44;
    cyc();
    wif.s_data = 8'h55;
    #2 chk("pp_ready", 32'(wif.s_ready), 1);
    chk("pp_inc", 32'(wif.w_inc), 1);
    chk("pp_data44", 32'(wif.w_data), 32'h44);
    cyc();
    wif.s_valid = 1'b0;
    #2 chk("pp_data55", 32'(wif.w_data), 32'h55);
    chk("pp_inc2", 32'(wif.w_inc), 1);
    cyc();
    #2 chk("pp_idle", 32'(wif.w_inc), 0);
    chk("pp_words", 32'(wr_words), 14);

    // Fill to TWO with en=0, then flush
    cyc();
    en = 1'b0; wif.s_valid = 1'b1; wif.s_data = 8'h66;
    #2 chk("en0_noinc", 32'(wif.w_inc), 0);
    cyc();
    wif.s_data = 8'h67;
    #2 chk("en0_ready", 32'(wif.s_ready), 1);
    chk("en0_noinc2", 32'(wif.w_inc), 0);
    cyc();
    wif.s_data = 8'h68; flush = 1'b1; en = 1'b1;
    #2 chk("fl_ready", 32'(wif.s_ready), 0);
    chk("fl_noinc", 32'(wif.w_inc), 0);
    cyc();
    flush = 1'b0; wif.s_data = 8'h77;
    #2 chk("fl_empty_inc", 32'(wif.w_inc), 0);
    chk("fl_empty_data", 32'(wif.w_data), 0);
    chk("fl_ready77", 32'(wif.s_ready), 1);
    cyc();
    wif.s_valid = 1'b0;
    #2 chk("fl_inc77", 32'(wif.w_inc), 1);
    chk("fl_data77", 32'(wif.w_data), 32'h77);
    cyc();
    #2 chk("fl_idle", 32'(wif.w_inc), 0);
    chk("fl_words", 32'(wr_words), 15);
    chk("fl_stall", 32'(stall_cnt), 2);

    // Stall saturation at 2^CW-1
    cyc();
    wif.full = 1'b1; wif.s_valid = 1'b1; wif.s_data = 8'h90;
    #2 chk("sat_acc", 32'(wif.s_ready), 1);
    cyc();
    wif.s_valid = 1'b0;
    for (int k = 0; k < 32; k++) begin
      #2 chk("sat_stall", 32'(stall_cnt), (2 + k > 31) ? 31 : 2 + k);
      chk("sat_noinc", 32'(wif.w_inc), 0);
      cyc();
    end
    #2 chk("sat_max", 32'(stall_cnt), 31);

    // clr_stats coinciding with a write
    wif.full = 1'b0; clr_stats = 1'b1;
    #1 chk("clr_inc", 32'(wif.w_inc), 1);
    chk("clr_data", 32'(wif.w_data), 32'h90);
    cyc();
    clr_stats = 1'b0;
    #2 chk("clr_words", 32'(wr_words), 0);
    chk("clr_stall", 32'(stall_cnt), 0);

    // 33 words: wr_words wraps to 1
    for (int k = 0; k <= 32; k++) begin
      cyc();
      wif.s_valid = 1'b1; wif.s_data = 8'(k);
      #2 if (k > 0) chk("wrap_data", 32'(wif.w_data), 32'(k - 1));
    end
    cyc();
    wif.s_valid = 1'b0;
    #2 chk("wrap_last", 32'(wif.w_data), 32);
    cyc();
    #2 chk("wrap_words", 32'(wr_words), 1);

    // Asynchronous reset mid-stream
    cyc();
    wif.s_valid = 1'b1; wif.s_data = 8'hC3;
    cyc();
    wif.s_data = 8'hC4;
    #1 chk("mid_inc", 32'(wif.w_inc), 1);
    w_rstn = 1'b0;
    #1 chk("mid_rst_inc", 32'(wif.w_inc), 0);
    chk("mid_rst_ready", 32'(wif.s_ready), 0);
    chk("mid_rst_words", 32'(wr_words), 0);
    chk("mid_rst_data", 32'(wif.w_data), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
